ls74_bus_arbiter: RTL and testbench
===================================

// Module: ls74_bus_arbiter
// PURPOSE
//  Two-requester arbiter for a single shared resource, e.g. main/sub CPU access to shared RAM.
//  It replaces the discrete LS74-pair arbitration in the System86 shared-RAM path.
//  It registers active-low requests, issues one exclusive grant with round-robin fairness,
//  holds the grant for a minimum access time and inserts guard cycles between owners.
//  Its wait outputs stall the losing requester.
// PARAMETERS
//  ACCESS_CYCLES  2  minimum cycles a grant is held once issued (>=1)
//  GUARD_CYCLES   1  dead cycles with no grant between two grants (0 = back-to-back allowed)
//  HOLD_LIMIT     8  max grant cycles while the other side waits; 0 = unlimited (no preemption)
// PORTS
//  CLK     in   1  system clock, all state updates on rising edge
//  nCLR    in   1  asynchronous active-low reset
//  nREQ_A  in   1  requester A access request, active low, level-held for the whole access
//  nREQ_B  in   1  requester B access request, active low
//  nGNT_A  out  1  grant to A, active low, registered
//  nGNT_B  out  1  grant to B, active low, registered
//  nWAIT_A out  1  stall A, active low; combinational: low when nREQ_A=0 and nGNT_A=1
//  nWAIT_B out  1  stall B, active low; same rule for B
//  SEL     out  1  datapath mux select, registered: 0=A, 1=B; holds the last owner when idle
//  nCS     out  1  resource chip select, active low, registered; equals nGNT_A & nGNT_B
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  - nCLR=0 forces IDLE immediately, regardless of CLK.
//  - Reset values: nGNT_A=nGNT_B=1, nCS=1, SEL=0, counters=0, last_owner=B (A wins first tie).
//  - nCLR deassertion takes effect on the first CLK edge with nCLR=1.
//  Inputs are sampled on the rising CLK edge; no internal synchroniser (the caller provides one).
//  FSM states: IDLE, GNT_A, GNT_B, GUARD.
//  IDLE
//   - Only A requesting -> GNT_A. Only B requesting -> GNT_B.
//   - Both requesting -> grant the side != last_owner (round robin).
//   - No request -> stay in IDLE.
//   - Latency: request sampled at edge N gives its grant output low after edge N+1... 
//     precisely, the grant output is low from edge N (registered output of that transition).
//  GNT_x
//   - hold_cnt counts from 1 on entry and saturates at max(ACCESS_CYCLES, HOLD_LIMIT).
//   - Leave when own request is released and hold_cnt>=ACCESS_CYCLES.
//   - Also leave (preempt) when HOLD_LIMIT!=0, hold_cnt>=HOLD_LIMIT and the other side is requesting.
//   - Before ACCESS_CYCLES the grant holds even if the request drops.
//   - Exit sets last_owner=x and goes to GUARD, or to IDLE when GUARD_CYCLES=0.
//   - With GUARD_CYCLES=0 the IDLE arbitration happens on the same edge, so the other grant
//     follows with no gap.
//  GUARD
//   - All grants are high. The counter runs GUARD_CYCLES cycles, then IDLE arbitration applies.
//   - The preempted side still requesting waits for the next round-robin turn.
//  Exclusivity: nGNT_A and nGNT_B are never both low in any cycle.
//  SEL updates on the same edge the grant is asserted and is stable for the whole grant.
//  Counters are sized $clog2(max param)+1 and never wrap; they clear on every state entry.
//  Requests that go high while waiting are dropped with no memory (no latched pending).
//  A request asserted and deasserted within a guard period is never granted.
// TESTING
//  1. Reset low mid-GNT_B: nGNT_B->1, nCS->1 asynchronously without a CLK edge;
//     after release with both requesting, A is granted first.
//  2. A alone, 3-cycle request (defaults): nGNT_A low 3 cycles, SEL=0, nWAIT_A never low;
//     then 1 guard cycle with nCS=1.
//  3. A and B asserted on the same edge: A granted, nWAIT_B low throughout;
//     after A releases and 1 guard cycle, B granted, SEL=1.
//  4. A holds its request forever, B requests: A is preempted after 8 grant cycles, then
//     1 guard cycle, then B is granted; nWAIT_A is low while B is owner.
//  5. 1-cycle A pulse: grant held exactly ACCESS_CYCLES=2 cycles.
//  6. GUARD_CYCLES=0 and HOLD_LIMIT=0 with both requesting: grants alternate with no gap
//     at each release, no preemption; exclusivity asserted every cycle.

Source files
------------

// File: rtl/ls74_bus_arbiter.sv
// ls74_bus_arbiter: two-requester round-robin arbiter for a shared resource.
// Ports:
//   CLK           rising-edge system clock
//   nCLR          asynchronous active-low reset
//   nREQ_A/nREQ_B active-low access requests, level-held for the whole access
//   nGNT_A/nGNT_B active-low exclusive grants (registered)
//   nWAIT_A/B     active-low stall, low while requesting and not granted (combinational)
//   SEL           datapath select, 0=A 1=B, holds last owner when idle (registered)
//   nCS           active-low resource chip select, low while any grant is low (registered)
module ls74_bus_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int GUARD_CYCLES  = 1,
    parameter int HOLD_LIMIT    = 8
) (
    input  logic CLK,
    input  logic nCLR,
    input  logic nREQ_A,
    input  logic nREQ_B,
    output logic nGNT_A,
    output logic nGNT_B,
    output logic nWAIT_A,
    output logic nWAIT_B,
    output logic SEL,
    output logic nCS
);
    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, GUARD} state_t;
    localparam int SAT  = ACCESS_CYCLES > HOLD_LIMIT ? ACCESS_CYCLES : HOLD_LIMIT;
    localparam int MAXP = SAT > GUARD_CYCLES ? SAT : GUARD_CYCLES;
    localparam int CW   = $clog2(MAXP) + 1;

    state_t state, nextState;
    logic [CW-1:0] holdCnt, guardCnt;
    logic lastOwner, nextLast;
    logic reqA, reqB, exitA, exitB;

    assign reqA = ~nREQ_A;
    assign reqB = ~nREQ_B;
    assign nWAIT_A = nREQ_A | ~nGNT_A;
    assign nWAIT_B = nREQ_B | ~nGNT_B;

    // lastB=1 means B owned last, so A wins a tie
    function automatic state_t arbitrate(input logic a, input logic b, input logic lastB);
        return (a && (!b || lastB)) ? GNT_A : b ? GNT_B : IDLE;
    endfunction

    // Leave on release after the minimum access, or on preemption once the other side has waited long enough
    assign exitA = (!reqA && int'(holdCnt) >= ACCESS_CYCLES) ||
                   (HOLD_LIMIT != 0 && int'(holdCnt) >= HOLD_LIMIT && reqB);
    assign exitB = (!reqB && int'(holdCnt) >= ACCESS_CYCLES) ||
                   (HOLD_LIMIT != 0 && int'(holdCnt) >= HOLD_LIMIT && reqA);

    // With no guard time the next owner is arbitrated on the same edge as the release
    always_comb begin
        nextState = state;
        nextLast = lastOwner;
        case (state)
            IDLE: nextState = arbitrate(reqA, reqB, lastOwner);
            GNT_A: begin
                nextLast = exitA ? 1'b0 : lastOwner;
                nextState = !exitA ? GNT_A : GUARD_CYCLES == 0 ? arbitrate(reqA, reqB, 1'b0) : GUARD;
            end
            GNT_B: begin
                nextLast = exitB ? 1'b1 : lastOwner;
                nextState = !exitB ? GNT_B : GUARD_CYCLES == 0 ? arbitrate(reqA, reqB, 1'b1) : GUARD;
            end
            GUARD: nextState = int'(guardCnt) >= GUARD_CYCLES ? arbitrate(reqA, reqB, lastOwner) : GUARD;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state     <= IDLE;
            lastOwner <= 1'b1;
            holdCnt   <= '0;
            guardCnt  <= '0;
            nGNT_A    <= 1'b1;
            nGNT_B    <= 1'b1;
            nCS       <= 1'b1;
            SEL       <= 1'b0;
        end else begin
            state     <= nextState;
            lastOwner <= nextLast;
            holdCnt   <= !(nextState == GNT_A || nextState == GNT_B) ? '0 :
                         nextState != state ? CW'(1) :
                         holdCnt + CW'(int'(holdCnt) < SAT);
            guardCnt  <= nextState != GUARD ? '0 :
                         state != GUARD ? CW'(1) :
                         guardCnt + CW'(int'(guardCnt) < GUARD_CYCLES);
            nGNT_A    <= nextState != GNT_A;
            nGNT_B    <= nextState != GNT_B;
            nCS       <= !(nextState == GNT_A || nextState == GNT_B);
            SEL       <= nextState == GNT_B ? 1'b1 : nextState == GNT_A ? 1'b0 : SEL;
        end
    end
endmodule

// File: tb/tb_ls74_bus_arbiter.sv
// tb_ls74_bus_arbiter: directed vector bench for ls74_bus_arbiter (default and no-guard/no-limit builds).
module tb_ls74_bus_arbiter;
    logic CLK = 1'b0;
    logic nCLR = 1'b0;
    logic nReqA = 1'b1, nReqB = 1'b1, nReqA0 = 1'b1, nReqB0 = 1'b1;
    logic gA, gB, wA, wB, sel, cs;
    logic gA0, gB0, wA0, wB0, sel0, cs0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic rA;
        logic rB;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    always #5 CLK = ~CLK;

    ls74_bus_arbiter dut (
        .CLK(CLK), .nCLR(nCLR), .nREQ_A(nReqA), .nREQ_B(nReqB),
        .nGNT_A(gA), .nGNT_B(gB), .nWAIT_A(wA), .nWAIT_B(wB), .SEL(sel), .nCS(cs)
    );

    ls74_bus_arbiter #(.ACCESS_CYCLES(2), .GUARD_CYCLES(0), .HOLD_LIMIT(0)) dut0 (
        .CLK(CLK), .nCLR(nCLR), .nREQ_A(nReqA0), .nREQ_B(nReqB0),
        .nGNT_A(gA0), .nGNT_B(gB0), .nWAIT_A(wA0), .nWAIT_B(wB0), .SEL(sel0), .nCS(cs0)
    );

    // Output words are {nGNT_A, nGNT_B, nWAIT_A, nWAIT_B, SEL, nCS}
    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic a, input logic b);
        @(negedge CLK);
        nReqA = a;
        nReqB = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic step0(input logic a, input logic b);
        @(negedge CLK);
        nReqA0 = a;
        nReqB0 = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic a, input logic b, input logic [5:0] e, input int n);
        for (int i = 0; i < n; i++) tbl.push_back({a, b, e});
    endtask

    always @(negedge CLK) begin
        if (nCLR) begin
            checks++;
            if (!gA && !gB) begin
                errors++;
                $display("FAIL excl_default: nGNT_A=%b nGNT_B=%b both low", gA, gB);
            end
            if (!gA0 && !gB0) begin
                errors++;
                $display("FAIL excl_noguard: nGNT_A=%b nGNT_B=%b both low", gA0, gB0);
            end
        end
    end

    initial begin
        // both asserted together after reset: A first, then B after one guard cycle
        add(0, 0, 6'b011000, 2);
        add(1, 0, 6'b111001, 1);
        add(1, 0, 6'b101110, 2);
        add(1, 1, 6'b111111, 2);
        // A alone for three cycles, then one guard cycle
        add(0, 1, 6'b011100, 3);
        add(1, 1, 6'b111101, 2);
        // one-cycle A pulse keeps the grant for the minimum access time
        add(0, 1, 6'b011100, 1);
        add(1, 1, 6'b011100, 1);
        add(1, 1, 6'b111101, 2);
        // A holds forever, B waits: preempted after 8 grant cycles
        add(0, 1, 6'b011100, 1);
        add(0, 0, 6'b011000, 7);
        add(0, 0, 6'b110001, 1);
        add(0, 0, 6'b100110, 2);
        add(0, 1, 6'b110111, 1);
        add(0, 1, 6'b011100, 1);
        add(1, 1, 6'b011100, 1);
        add(1, 1, 6'b111101, 2);

        #12;
        chk("reset_default", {gA, gB, wA, wB, sel, cs}, 6'b111101);
        chk("reset_noguard", {gA0, gB0, wA0, wB0, sel0, cs0}, 6'b111101);
        @(negedge CLK);
        nCLR = 1'b1;
        foreach (tbl[i]) begin
            step(tbl[i].rA, tbl[i].rB);
            chk($sformatf("vec%0d", i), {gA, gB, wA, wB, sel, cs}, tbl[i].exp);
        end

        // asynchronous reset in the middle of a B grant
        step(1, 0);
        chk("b_grant_before_reset", {gA, gB, wA, wB, sel, cs}, 6'b101110);
        #2;
        nCLR = 1'b0;
        #1;
        chk("async_reset", {gA, gB, wA, wB, sel, cs}, 6'b111001);
        nReqA = 1'b0;
        @(negedge CLK);
        nCLR = 1'b1;
        @(posedge CLK);
        #1;
        chk("a_first_after_reset", {gA, gB, wA, wB, sel, cs}, 6'b011000);
        step(1, 1);
        step(1, 1);
        chk("release_after_reset", {gA, gB, wA, wB, sel, cs}, 6'b111101);

        // no guard and no hold limit: no preemption, gap-free handover
        for (int i = 0; i < 10; i++) begin
            step0(0, 0);
            chk($sformatf("ng_hold_a%0d", i), {gA0, gB0, wA0, wB0, sel0, cs0}, 6'b011000);
        end
        step0(1, 0);
        chk("ng_handover_b", {gA0, gB0, wA0, wB0, sel0, cs0}, 6'b101110);
        for (int i = 0; i < 3; i++) begin
            step0(0, 0);
            chk($sformatf("ng_hold_b%0d", i), {gA0, gB0, wA0, wB0, sel0, cs0}, 6'b100110);
        end
        step0(0, 1);
        chk("ng_handover_a", {gA0, gB0, wA0, wB0, sel0, cs0}, 6'b011100);
        step0(1, 1);
        chk("ng_min_access", {gA0, gB0, wA0, wB0, sel0, cs0}, 6'b011100);
        step0(1, 1);
        chk("ng_idle", {gA0, gB0, wA0, wB0, sel0, cs0}, 6'b111101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
